// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the sclk-domain clock-enable generator.
// Divisors are half-periods of the level output, counted in sclk cycles.
package clk_div_pkg;

    localparam int unsigned SYS_HZ    = 100_000_000;
    localparam int unsigned DEF_CNT_W = 32;

    // Half-period divisor that gives a level output of the requested frequency
    function automatic logic [DEF_CNT_W-1:0] hz_to_div(input int unsigned hz);
        return DEF_CNT_W'(SYS_HZ / (2 * hz));
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, shadow/active divisor pair, registered tick and level.
// A new divisor is held in the shadow and only takes effect at a wrap or on restart.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int unsigned      CNT_W     = DEF_CNT_W,
    parameter logic [CNT_W-1:0] DIV_RESET = CNT_W'(1)
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_data,
    output logic             tick,
    output logic             level,
    output logic             pending
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_active;
    logic [CNT_W-1:0] div_shadow;
    logic [CNT_W-1:0] last;
    logic             wrap;

    // A zero divisor behaves like one, so the terminal count is zero in both cases
    assign last = (div_active == '0) ? '0 : div_active - CNT_W'(1);
    assign wrap = en && (cnt == last);

    always_ff @(posedge sclk) begin
        if (rst) begin
            cnt        <= '0;
            div_active <= DIV_RESET;
            div_shadow <= DIV_RESET;
            tick       <= 1'b0;
            level      <= 1'b0;
            pending    <= 1'b0;
        end else if (restart) begin
            cnt   <= '0;
            tick  <= 1'b0;
            level <= 1'b0;
            if (wr) begin
                div_active <= wr_data;
                div_shadow <= wr_data;
                pending    <= 1'b0;
            end else if (pending) begin
                div_active <= div_shadow;
                pending    <= 1'b0;
            end
        end else begin
            tick <= wrap;
            if (en) begin
                cnt <= wrap ? '0 : cnt + CNT_W'(1);
            end
            if (wrap) begin
                level <= ~level;
                if (pending) begin
                    div_active <= div_shadow;
                end
            end
            // A write landing on the wrap cycle stays pending for the following period
            if (wr) begin
                div_shadow <= wr_data;
                pending    <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel tick/level generator; sclk stays the only clock for downstream logic.
// This level only decodes the divisor write channel and fans restart out to all channels.
module clk_enable_gen
    import clk_div_pkg::*;
#(
    parameter int unsigned                   NUM_CH      = 3,
    parameter int unsigned                   CNT_W       = DEF_CNT_W,
    parameter logic [NUM_CH*CNT_W-1:0]       DIV_DEFAULT = {hz_to_div(400), hz_to_div(2), hz_to_div(1)},
    localparam int unsigned                  CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              en,
    input  logic              restart,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [CNT_W-1:0]  div_in,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] div_pending
);

    logic [NUM_CH-1:0] wr_sel;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Out-of-range channel numbers match no channel and are dropped
        assign wr_sel[i] = div_wr && (div_ch == CH_W'(i));

        clk_div_channel #(
            .CNT_W     (CNT_W),
            .DIV_RESET (DIV_DEFAULT[i*CNT_W +: CNT_W])
        ) u_channel (
            .sclk    (sclk),
            .rst     (rst),
            .en      (en),
            .restart (restart),
            .wr      (wr_sel[i]),
            .wr_data (div_in),
            .tick    (tick[i]),
            .level   (level[i]),
            .pending (div_pending[i])
        );
    end

endmodule
